// File: rtl/geffe_gen_param_if.sv
// geffe_gen_param_if: control inputs and generated-bit outputs of geffe_gen_param
interface geffe_gen_param_if #(
  parameter int N = 4,
  parameter int W = 32
);
  logic en;
  logic mode;
  logic seed_ld;
  logic [$clog2(N+1)-1:0] seed_idx;
  logic [W-1:0] seed_data;
  logic gefout;
  logic gef_valid;
  modport master (output en, mode, seed_ld, seed_idx, seed_data, input gefout, gef_valid);
  modport slave (input en, mode, seed_ld, seed_idx, seed_data, output gefout, gef_valid);
endinterface

// File: rtl/geffe_gen_param.sv
// geffe_gen_param: Geffe-style PRBG, N divided-rate data LFSRs picked (or XORed) by a full-rate selector LFSR
module geffe_gen_param #(
  parameter int N = 4,
  parameter int W = 32,
  parameter logic [W-1:0] TAPS = W'(32'h8020_0003),
  parameter logic [W-1:0] SEED_BASE = W'(32'h0000_0001),
  parameter int DIV = 2
) (
  input logic clk,
  input logic rst_n,
  geffe_gen_param_if.slave bus
);
  localparam int SEL_W = $clog2(N);
  localparam int IDX_W = $clog2(N + 1);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  function automatic logic [W-1:0] step(input logic [W-1:0] s);
    return {s[W-2:0], ^(s & TAPS)};
  endfunction
  function automatic logic [W-1:0] rotl(input logic [W-1:0] s, input int k);
    logic [W-1:0] r;
    r = '0;
    for (int j = 0; j < W; j++) r[(j + k) % W] = s[j];
    return r;
  endfunction
  function automatic logic [W-1:0] rev(input logic [W-1:0] s);
    logic [W-1:0] r;
    r = '0;
    for (int j = 0; j < W; j++) r[j] = s[W-1-j];
    return r;
  endfunction
  localparam logic [W-1:0] SEL_RST = rev(SEED_BASE);
  logic [W-1:0] sel_q, sel_d;
  logic [N-1:0][W-1:0] dat_q, dat_d;
  logic [N-1:0] dat_bit;
  logic [SEL_W-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic gef_q, gef_d, vld_q;
  logic ld_ok, wrap;
  // a zero seed would lock an LFSR, so such loads are dropped outright
  assign ld_ok = bus.seed_ld && |bus.seed_data;
  assign wrap = bus.en && cnt_q == CW'(DIV - 1);
  assign sel_d = ld_ok && bus.seed_idx == '0 ? bus.seed_data
               : ~|sel_q ? SEL_RST
               : bus.en ? step(sel_q) : sel_q;
  assign sr_d = bus.en ? SEL_W'({sr_q, sel_q[W-1]}) : sr_q;
  assign cnt_d = bus.en ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
  assign gef_d = bus.en ? (bus.mode ? ^dat_bit : dat_bit[sr_q]) : gef_q;
  for (genvar i = 0; i < N; i++) begin : g_dat
    localparam logic [W-1:0] RST_V = rotl(SEED_BASE, (i + 1) % W);
    assign dat_bit[i] = dat_q[i][W-1];
    assign dat_d[i] = ld_ok && bus.seed_idx == IDX_W'(i + 1) ? bus.seed_data
                    : ~|dat_q[i] ? RST_V
                    : wrap ? step(dat_q[i]) : dat_q[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= SEL_RST;
      for (int i = 0; i < N; i++) dat_q[i] <= rotl(SEED_BASE, (i + 1) % W);
      sr_q <= '0;
      cnt_q <= '0;
      gef_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      dat_q <= dat_d;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      gef_q <= gef_d;
      vld_q <= bus.en;
    end
  end
  assign bus.gefout = gef_q;
  assign bus.gef_valid = vld_q;
endmodule

// File: tb/tb_geffe_gen_param.sv
// tb_geffe_gen_param: drives a small 8-bit instance and a default instance against a behavioural model
module tb_geffe_gen_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int chk = 0;
  int pass = 0;
  always #5 clk = ~clk;
  geffe_gen_param_if #(.N(4), .W(8)) bs();
  geffe_gen_param_if #(.N(4), .W(32)) bd();
  geffe_gen_param #(.N(4), .W(8), .TAPS(8'hB8), .SEED_BASE(8'h01), .DIV(3)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bs));
  geffe_gen_param dut_d (.clk(clk), .rst_n(rst_n), .bus(bd));
  // model: instance 0 = small (W=8, DIV=3), instance 1 = default (W=32, DIV=2)
  int cw[2] = '{8, 32};
  int cdiv[2] = '{3, 2};
  logic [63:0] ctaps[2] = '{64'hB8, 64'h8020_0003};
  logic [63:0] m_dat[2][4];
  logic [63:0] m_sel[2];
  int m_q[2], m_cnt[2];
  bit m_out[2], m_val[2];
  function automatic logic [63:0] msk(int d);
    return (64'd1 << cw[d]) - 64'd1;
  endfunction
  function automatic logic [63:0] nxt(int d, logic [63:0] s);
    return ((s << 1) | 64'(^(s & ctaps[d]))) & msk(d);
  endfunction
  function automatic logic [63:0] dat_rst(int d, int i);
    return 64'd1 << ((i + 1) % cw[d]);
  endfunction
  function automatic logic [63:0] sel_rst(int d);
    return 64'd1 << (cw[d] - 1);
  endfunction
  function automatic logic [63:0] steps(int d, logic [63:0] s, int n);
    for (int k = 0; k < n; k++) s = nxt(d, s);
    return s;
  endfunction
  function automatic logic [63:0] upd(int d, logic [63:0] s, bit ld, logic [63:0] v, bit go, logic [63:0] rv);
    if (ld) return v;
    if (s == 0) return rv;
    return go ? nxt(d, s) : s;
  endfunction
  task automatic model_reset(int d);
    for (int i = 0; i < 4; i++) m_dat[d][i] = dat_rst(d, i);
    m_sel[d] = sel_rst(d);
    m_q[d] = 0;
    m_cnt[d] = 0;
    m_out[d] = 0;
    m_val[d] = 0;
  endtask
  task automatic model_edge(int d, bit en, bit mode, bit ld, int idx, logic [63:0] data);
    logic [3:0] b;
    bit wr, sb, lv;
    data = data & msk(d);
    for (int i = 0; i < 4; i++) b[i] = m_dat[d][i][cw[d]-1];
    sb = m_sel[d][cw[d]-1];
    wr = en && m_cnt[d] == cdiv[d] - 1;
    lv = ld && data != 0;
    if (en) m_out[d] = mode ? ^b : b[m_q[d]];
    m_val[d] = en;
    m_sel[d] = upd(d, m_sel[d], lv && idx == 0, data, en, sel_rst(d));
    for (int i = 0; i < 4; i++) m_dat[d][i] = upd(d, m_dat[d][i], lv && idx == i + 1, data, wr, dat_rst(d, i));
    if (en) begin
      m_q[d] = (m_q[d] * 2 + int'(sb)) % 4;
      m_cnt[d] = (m_cnt[d] + 1) % cdiv[d];
    end
  endtask
  task automatic cyc(int d, bit en, bit mode, bit ld, int idx, logic [63:0] data);
    if (d == 0) begin
      bs.en = en; bs.mode = mode; bs.seed_ld = ld; bs.seed_idx = 3'(idx); bs.seed_data = 8'(data);
      bd.en = 1'b0; bd.seed_ld = 1'b0;
    end else begin
      bd.en = en; bd.mode = mode; bd.seed_ld = ld; bd.seed_idx = 3'(idx); bd.seed_data = 32'(data);
      bs.en = 1'b0; bs.seed_ld = 1'b0;
    end
    @(posedge clk);
    model_edge(d, en, mode, ld, idx, data);
    model_edge(1 - d, 1'b0, 1'b0, 1'b0, 0, 64'd0);
    #1;
  endtask
  task automatic reset_pulse;
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    model_reset(0);
    model_reset(1);
  endtask
  task automatic test_reset;
    chk++; if (bs.gefout !== 1'b0 || bs.gef_valid !== 1'b0) $display("FAIL reset_out: got %b/%b want 0/0", bs.gefout, bs.gef_valid); else pass++;
    chk++; if (dut_s.dat_q[0] !== 8'h02) $display("FAIL reset_dat0: got %h want 02", dut_s.dat_q[0]); else pass++;
    chk++; if (dut_s.sel_q !== 8'h80) $display("FAIL reset_sel: got %h want 80", dut_s.sel_q); else pass++;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) cyc(0, 1'b1, 1'b0, 1'b0, 0, 0);
    chk++; if (bs.gef_valid !== 1'b1 || bs.gefout !== m_out[0]) $display("FAIL run_before_reset: got %b/%b want 1/%b", bs.gef_valid, bs.gefout, m_out[0]); else pass++;
    #2 rst_n = 1'b0;
    #1;
    chk++; if (bs.gefout !== 1'b0 || bs.gef_valid !== 1'b0) $display("FAIL async_reset_out: got %b/%b want 0/0", bs.gefout, bs.gef_valid); else pass++;
    chk++; if (dut_s.dat_q[0] !== 8'h02 || dut_s.sel_q !== 8'h80) $display("FAIL async_reset_state: got %h/%h want 02/80", dut_s.dat_q[0], dut_s.sel_q); else pass++;
    rst_n = 1'b1;
    model_reset(0);
    model_reset(1);
  endtask
  task automatic test_seed_load;
    logic [7:0] exp [4] = '{8'h02, 8'h04, 8'h08, 8'h11};
    cyc(0, 1'b0, 1'b0, 1'b1, 0, 64'h01);
    chk++; if (dut_s.sel_q !== 8'h01) $display("FAIL sel_load: got %h want 01", dut_s.sel_q); else pass++;
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1'b1, 1'b0, 1'b0, 0, 0);
      chk++; if (dut_s.sel_q !== exp[k]) $display("FAIL sel_step%0d: got %h want %h", k, dut_s.sel_q, exp[k]); else pass++;
      chk++; if (bs.gefout !== m_out[0]) $display("FAIL sel_step_out%0d: got %b want %b", k, bs.gefout, m_out[0]); else pass++;
    end
  endtask
  task automatic test_zero_seed;
    logic [63:0] sv [4];
    logic [63:0] ss;
    for (int i = 0; i < 4; i++) sv[i] = m_dat[0][i];
    ss = m_sel[0];
    cyc(0, 1'b0, 1'b0, 1'b1, 3, 0);
    chk++; if (dut_s.dat_q[2] !== 8'(sv[2])) $display("FAIL zero_seed: got %h want %h", dut_s.dat_q[2], 8'(sv[2])); else pass++;
    cyc(0, 1'b0, 1'b0, 1'b1, 5, 64'hFF);
    for (int i = 0; i < 4; i++) begin
      chk++; if (dut_s.dat_q[i] !== 8'(sv[i])) $display("FAIL bad_idx_dat%0d: got %h want %h", i, dut_s.dat_q[i], 8'(sv[i])); else pass++;
    end
    chk++; if (dut_s.sel_q !== 8'(ss)) $display("FAIL bad_idx_sel: got %h want %h", dut_s.sel_q, 8'(ss)); else pass++;
  endtask
  task automatic test_divider;
    int e = 0;
    logic [7:0] exp;
    reset_pulse();
    for (int t = 0; t < 14; t++) begin
      bit en = !(t == 9 || t == 10);
      cyc(0, en, 1'b0, 1'b0, 0, 0);
      e += int'(en);
      exp = 8'(steps(0, dat_rst(0, 0), e / 3));
      chk++; if (dut_s.dat_q[0] !== exp) $display("FAIL div_t%0d: got %h want %h", t, dut_s.dat_q[0], exp); else pass++;
      chk++; if (bs.gef_valid !== en || bs.gefout !== m_out[0]) $display("FAIL div_out_t%0d: got %b/%b want %b/%b", t, bs.gef_valid, bs.gefout, en, m_out[0]); else pass++;
    end
  endtask
  task automatic test_combine;
    cyc(0, 1'b0, 1'b0, 1'b1, 1, 64'hFF);
    for (int i = 2; i <= 4; i++) cyc(0, 1'b0, 1'b0, 1'b1, i, 64'h01);
    cyc(0, 1'b0, 1'b0, 1'b1, 0, 64'h01);
    cyc(0, 1'b1, 1'b0, 1'b0, 0, 0);
    cyc(0, 1'b1, 1'b0, 1'b0, 0, 0);
    cyc(0, 1'b1, 1'b0, 1'b0, 0, 0);
    chk++; if (bs.gefout !== 1'b1) $display("FAIL mux_q0: got %b want 1", bs.gefout); else pass++;
    cyc(0, 1'b1, 1'b1, 1'b0, 0, 0);
    chk++; if (bs.gefout !== 1'b1) $display("FAIL xor_1000: got %b want 1", bs.gefout); else pass++;
    cyc(0, 1'b0, 1'b1, 1'b1, 2, 64'hFF);
    cyc(0, 1'b1, 1'b1, 1'b0, 0, 0);
    chk++; if (bs.gefout !== 1'b0) $display("FAIL xor_1100: got %b want 0", bs.gefout); else pass++;
  endtask
  task automatic test_back_to_back;
    reset_pulse();
    cyc(0, 1'b1, 1'b0, 1'b0, 0, 0);
    cyc(0, 1'b1, 1'b0, 1'b0, 0, 0);
    cyc(0, 1'b1, 1'b0, 1'b1, 2, 64'h5A);
    chk++; if (dut_s.dat_q[1] !== 8'h5A) $display("FAIL ld_wrap_target: got %h want 5a", dut_s.dat_q[1]); else pass++;
    chk++; if (dut_s.dat_q[0] !== 8'(nxt(0, dat_rst(0, 0)))) $display("FAIL ld_wrap_other0: got %h want %h", dut_s.dat_q[0], 8'(nxt(0, dat_rst(0, 0)))); else pass++;
    chk++; if (dut_s.dat_q[2] !== 8'(nxt(0, dat_rst(0, 2)))) $display("FAIL ld_wrap_other2: got %h want %h", dut_s.dat_q[2], 8'(nxt(0, dat_rst(0, 2)))); else pass++;
    chk++; if (bs.gefout !== m_out[0] || bs.gef_valid !== 1'b1) $display("FAIL ld_wrap_out: got %b/%b want %b/1", bs.gefout, bs.gef_valid, m_out[0]); else pass++;
  endtask
  task automatic test_stats;
    int ones = 0;
    int bad = 0;
    for (int k = 0; k <= 4; k++) cyc(1, 1'b0, 1'b0, 1'b1, k, 64'($urandom | 32'd1));
    for (int k = 0; k < 65536; k++) begin
      cyc(1, 1'b1, 1'b0, 1'b0, 0, 0);
      ones += int'(bd.gefout);
      chk++; if (bd.gefout !== m_out[1]) begin bad++; if (bad < 10) $display("FAIL stat_bit%0d: got %b want %b", k, bd.gefout, m_out[1]); end else pass++;
    end
    chk++; if (ones < 32113 || ones > 33423) $display("FAIL ones_ratio: got %0d ones want 32113..33423", ones); else pass++;
    for (int k = 0; k < 3000; k++) begin
      bit en = ($urandom % 4) != 0;
      bit ld = ($urandom % 12) == 0;
      logic [63:0] v = ($urandom % 6) == 0 ? 64'd0 : 64'($urandom);
      cyc(1, en, 1'($urandom), ld, int'($urandom % 8), v);
      chk++; if (bd.gefout !== m_out[1] || bd.gef_valid !== m_val[1]) begin bad++; if (bad < 20) $display("FAIL mix%0d: got %b/%b want %b/%b", k, bd.gefout, bd.gef_valid, m_out[1], m_val[1]); end else pass++;
    end
  endtask
  initial begin
    bs.en = 1'b0; bs.mode = 1'b0; bs.seed_ld = 1'b0; bs.seed_idx = '0; bs.seed_data = '0;
    bd.en = 1'b0; bd.mode = 1'b0; bd.seed_ld = 1'b0; bd.seed_idx = '0; bd.seed_data = '0;
    model_reset(0);
    model_reset(1);
    #12;
    test_reset();
    test_seed_load();
    test_zero_seed();
    test_divider();
    test_combine();
    test_back_to_back();
    test_stats();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
